// File: rtl/uart_cal_pkg.sv
// Shared constants and types for the UART calculator datapath.
// Holds ASCII codes, operand type codes, operator codes and the
// result_encoder state enum, plus the nibble-to-ASCII helper.
package uart_cal_pkg;

  // ASCII characters used by the command parser and the result encoder
  localparam logic [7:0] ASC_EQ    = 8'h3D;
  localparam logic [7:0] ASC_MINUS = 8'h2D;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_E     = 8'h45;
  localparam logic [7:0] ASC_R     = 8'h52;
  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_0     = 8'h30;
  localparam logic [7:0] ASC_A     = 8'h41;

  // Operand type codes produced by the parser
  localparam logic [3:0] DT_SIGNED   = 4'h1;
  localparam logic [3:0] DT_UNSIGNED = 4'h2;

  // Operator codes produced by the parser
  localparam logic [3:0] ADD = 4'h1;
  localparam logic [3:0] SUB = 4'h2;
  localparam logic [3:0] MUL = 4'h3;
  localparam logic [3:0] DIV = 4'h4;

  // Encoder frame states; the presented byte belongs to the current state
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_PREFIX = 4'd1,
    ST_SIGN   = 4'd2,
    ST_DIGITS = 4'd3,
    ST_ERR0   = 4'd4,
    ST_ERR1   = 4'd5,
    ST_ERR2   = 4'd6,
    ST_CR     = 4'd7,
    ST_LF     = 4'd8
  } enc_state_t;

  // Uppercase hex digit for one nibble: 0-9 -> '0'-'9', 10-15 -> 'A'-'F'
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    logic [7:0] w_res;
    if (nib < 4'd10) begin
      w_res = ASC_0 + {4'h0, nib};
    end else begin
      w_res = ASC_A + {4'h0, nib} - 8'd10;
    end
    return w_res;
  endfunction

endpackage

// File: rtl/hex2ascii.sv
// Combinational nibble to uppercase ASCII hex digit converter.
module hex2ascii
  import uart_cal_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [7:0] o_ascii
);

  // Map the nibble onto its ASCII digit
  always_comb begin
    o_ascii = nibble_to_ascii(i_nibble);
  end

endmodule

// File: rtl/result_encoder.sv
// result_encoder: formats one ALU result as '=' ['-'] hex CR LF (or "ERR" CR LF
// on error) and streams it to uart_tx over a registered valid/ready handshake.
// Optional build macro: LEADING_ZERO_SUPPRESS_EN skips leading zero digits
// (at least one digit is always emitted).
module result_encoder
  import uart_cal_pkg::*;
#(
  parameter int         RES_W       = 32,
  parameter logic [3:0] SIGNED_CODE = 4'h1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RES_W-1:0] result,
  input  logic             result_err,
  input  logic [3:0]       dtype,
  input  logic             result_valid,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             enc_done
);

  localparam int NDIG  = RES_W / 4;
  localparam int CNT_W = $clog2(NDIG + 1);

  enc_state_t       r_state;
  logic [RES_W-1:0] r_mag;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             r_neg;

  logic             w_xfer;
  logic             w_neg;
  logic [RES_W-1:0] w_mag_in;
  logic [3:0]       w_nib;
  logic [7:0]       w_ascii;

  // Capture-side sign decode, handshake completion and next-digit selection
  always_comb begin
    w_xfer   = tx_valid & tx_ready;
    w_neg    = (dtype == SIGNED_CODE) & result[RES_W-1];
    w_mag_in = result;
    if (w_neg) begin
      w_mag_in = (~result) + {{(RES_W-1){1'b0}}, 1'b1};
    end else begin
      w_mag_in = result;
    end
    // While a digit is presented, the next one to load is the second nibble;
    // otherwise the top nibble is the one about to be presented.
    if ((r_state == ST_DIGITS) && tx_valid) begin
      w_nib = r_mag[RES_W-5 -: 4];
    end else begin
      w_nib = r_mag[RES_W-1 -: 4];
    end
  end

  hex2ascii u_hex2ascii (
    .i_nibble (w_nib),
    .o_ascii  (w_ascii)
  );

  // Frame FSM: loads the next byte into tx_data whenever the current one is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_mag    <= {RES_W{1'b0}};
      r_cnt    <= {CNT_W{1'b0}};
      r_err    <= 1'b0;
      r_neg    <= 1'b0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      enc_done <= 1'b0;
    end else begin
      enc_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (result_valid) begin
            r_err    <= result_err;
            r_neg    <= w_neg;
            r_mag    <= w_mag_in;
            r_cnt    <= CNT_W'(NDIG);
            tx_data  <= ASC_EQ;
            tx_valid <= 1'b1;
            busy     <= 1'b1;
            r_state  <= ST_PREFIX;
          end
        end
        ST_PREFIX: begin
          if (w_xfer) begin
            if (r_err) begin
              tx_data <= ASC_E;
              r_state <= ST_ERR0;
            end else if (r_neg) begin
              tx_data <= ASC_MINUS;
              r_state <= ST_SIGN;
            end else begin
              r_state <= ST_DIGITS;
`ifdef LEADING_ZERO_SUPPRESS_EN
              tx_valid <= 1'b0;
`else
              tx_data  <= w_ascii;
`endif
            end
          end
        end
        ST_SIGN: begin
          if (w_xfer) begin
            r_state <= ST_DIGITS;
`ifdef LEADING_ZERO_SUPPRESS_EN
            tx_valid <= 1'b0;
`else
            tx_data  <= w_ascii;
`endif
          end
        end
        ST_DIGITS: begin
`ifdef LEADING_ZERO_SUPPRESS_EN
          // Skip phase: nothing is presented, so dropping a zero nibble is safe
          if (!tx_valid) begin
            if ((r_cnt > CNT_W'(1)) && (r_mag[RES_W-1 -: 4] == 4'h0)) begin
              r_mag <= {r_mag[RES_W-5:0], 4'h0};
              r_cnt <= r_cnt - CNT_W'(1);
            end else begin
              tx_data  <= w_ascii;
              tx_valid <= 1'b1;
            end
          end else
`endif
          if (w_xfer) begin
            if (r_cnt == CNT_W'(1)) begin
              tx_data <= ASC_CR;
              r_state <= ST_CR;
            end else begin
              tx_data <= w_ascii;
              r_mag   <= {r_mag[RES_W-5:0], 4'h0};
              r_cnt   <= r_cnt - CNT_W'(1);
            end
          end
        end
        ST_ERR0: begin
          if (w_xfer) begin
            tx_data <= ASC_R;
            r_state <= ST_ERR1;
          end
        end
        ST_ERR1: begin
          if (w_xfer) begin
            tx_data <= ASC_R;
            r_state <= ST_ERR2;
          end
        end
        ST_ERR2: begin
          if (w_xfer) begin
            tx_data <= ASC_CR;
            r_state <= ST_CR;
          end
        end
        ST_CR: begin
          if (w_xfer) begin
            tx_data <= ASC_LF;
            r_state <= ST_LF;
          end
        end
        ST_LF: begin
          if (w_xfer) begin
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            enc_done <= 1'b1;
            r_state  <= ST_IDLE;
          end
        end
        default: begin
          tx_data  <= 8'h00;
          tx_valid <= 1'b0;
          busy     <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_encoder.sv
// Directed self-checking bench for result_encoder (expectations follow
// LEADING_ZERO_SUPPRESS_EN when the bench is built with it).
module tb_result_encoder;

  logic        clk;
  logic        rst;
  logic [31:0] result;
  logic        result_err;
  logic [3:0]  dtype;
  logic        result_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        enc_done;

  int checks;
  int errors;

  logic [7:0] got[$];
  int         done_cnt;
  int         cyc;
  int         first_cyc;
  int         last_cyc;
  logic       prev_stall;
  logic [7:0] prev_data;

  result_encoder #(.RES_W(32), .SIGNED_CODE(4'h1)) dut (
    .clk          (clk),
    .rst          (rst),
    .result       (result),
    .result_err   (result_err),
    .dtype        (dtype),
    .result_valid (result_valid),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .enc_done     (enc_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Byte monitor: records transfers, enc_done pulses and stall stability
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", {31'd0, tx_valid}, 32'd1);
        chk("stall_data", {24'd0, tx_data}, {24'd0, prev_data});
      end
      if (tx_valid && tx_ready) begin
        if (got.size() == 0) first_cyc = cyc;
        last_cyc = cyc;
        got.push_back(tx_data);
      end
      if (enc_done) done_cnt++;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got.delete();
    done_cnt = 0;
  endtask

  task automatic send(input logic [31:0] r, input logic e, input logic [3:0] dt);
    result       = r;
    result_err   = e;
    dtype        = dt;
    result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
    result       = 32'h0;
    result_err   = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic rnd);
    for (int i = 0; i < 300; i++) begin
      if (rnd) tx_ready = 1'($urandom_range(0, 1));
      tick();
      if (done_cnt > 0) break;
    end
    tx_ready = 1'b1;
    chk({tag, "_done"}, done_cnt, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic expect_frame(input string tag, input string body);
    int n;
    logic [7:0] e;
    n = body.len() + 2;
    chk({tag, "_len"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) begin
      if (i < body.len()) e = body[i];
      else if (i == body.len()) e = 8'h0D;
      else e = 8'h0A;
      chk($sformatf("%s_byte%0d", tag, i), {24'd0, got[i]}, {24'd0, e});
    end
  endtask

  initial begin
    checks = 0; errors = 0; done_cnt = 0; cyc = 0; first_cyc = 0; last_cyc = 0;
    prev_stall = 1'b0; prev_data = 8'h00;
    rst = 1'b1; result = 32'h0; result_err = 1'b0; dtype = 4'h0;
    result_valid = 1'b0; tx_ready = 1'b1;
    tick(); tick();
    chk("rst_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_data", {24'd0, tx_data}, 32'd0);
    chk("rst_done", {31'd0, enc_done}, 32'd0);
    rst = 1'b0;
    tick();

    // Unsigned value, tx_ready held high; also checks 1-cycle latency
    clear_mon();
    send(32'h0000_1A2F, 1'b0, 4'h2);
    @(negedge clk);
    chk("lat_valid", {31'd0, tx_valid}, 32'd1);
    chk("lat_data", {24'd0, tx_data}, 32'h3D);
    chk("lat_busy", {31'd0, busy}, 32'd1);
    wait_done("uns", 1'b0);
`ifdef LEADING_ZERO_SUPPRESS_EN
    expect_frame("uns", "=1A2F");
`else
    expect_frame("uns", "=00001A2F");
    chk("uns_consec", last_cyc - first_cyc, 32'd10);
`endif

    // Signed negative: -10
    clear_mon();
    send(32'hFFFF_FFF6, 1'b0, 4'h1);
    wait_done("neg", 1'b0);
`ifdef LEADING_ZERO_SUPPRESS_EN
    expect_frame("neg", "=-A");
`else
    expect_frame("neg", "=-0000000A");
`endif

    // Same bit pattern as unsigned prints raw
    clear_mon();
    send(32'hFFFF_FFF6, 1'b0, 4'h2);
    wait_done("unsmsb", 1'b0);
    expect_frame("unsmsb", "=FFFFFFF6");

    // Largest positive signed value has no sign
    clear_mon();
    send(32'h7FFF_FFFF, 1'b0, 4'h1);
    wait_done("pos", 1'b0);
    expect_frame("pos", "=7FFFFFFF");

    // Error path
    clear_mon();
    send(32'h1234_5678, 1'b1, 4'h1);
    wait_done("err", 1'b0);
    expect_frame("err", "=ERR");

    // Most negative value under random backpressure
    clear_mon();
    tx_ready = 1'b0;
    send(32'h8000_0000, 1'b0, 4'h1);
    wait_done("bp", 1'b1);
    expect_frame("bp", "=-80000000");

    // Second result_valid mid-frame must be ignored
    clear_mon();
    send(32'h1234_5678, 1'b0, 4'h2);
    tick(); tick();
    send(32'hDEAD_BEEF, 1'b1, 4'h1);
    wait_done("ovl", 1'b0);
    expect_frame("ovl", "=12345678");
    tick(); tick();
    chk("ovl_idle_valid", {31'd0, tx_valid}, 32'd0);

    // Reset in the middle of the digit phase
    clear_mon();
    send(32'h0000_ABCD, 1'b0, 4'h2);
    tick(); tick(); tick();
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_valid", {31'd0, tx_valid}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_data", {24'd0, tx_data}, 32'd0);
    clear_mon();
    tick(); tick(); tick();
    chk("mrst_quiet", got.size(), 32'd0);
    chk("mrst_nodone", done_cnt, 32'd0);

    // Zero after the abort
    clear_mon();
    send(32'h0000_0000, 1'b0, 4'h2);
    wait_done("zero", 1'b0);
`ifdef LEADING_ZERO_SUPPRESS_EN
    expect_frame("zero", "=0");
`else
    expect_frame("zero", "=00000000");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
